stream_fifo_flushable: RTL and testbench
========================================

# stream_fifo_flushable

Flushable ready/valid FIFO that buffers a stream of `T` items ahead of the flushable spill register in the NPC pipeline (e.g. fetched instructions awaiting decode). It absorbs bursts of up to `Depth` items and is flushed in the same cycle as the downstream spill register, so both discard in-flight data together on a redirect. Its output never presents `valid_o` while `flush_i` is high, which satisfies the downstream rule that flush and valid must not coincide.

## Interface
- `T`, default `logic`: payload type.
- `Depth`, default `4`: number of entries, at least 1, need not be a power of two.
- `CntW`, derived, `$clog2(Depth+1)`: width of the fill count.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset; synchronous and active-low.
- `flush_i`  in  1  discard all stored entries.
- `valid_i`  in  1  upstream item valid.
- `ready_o`  out  1  FIFO accepts an item this cycle.
- `data_i`  in  `T`  upstream item.
- `valid_o`  out  1  head item valid.
- `ready_i`  in  1  downstream accepts the head item.
- `data_o`  out  `T`  head item.
- `usage_o`  out  `CntW`  number of stored entries, 0..`Depth`.
- `full_o`  out  1  `usage_o == Depth`.
- `empty_o`  out  1  `usage_o == 0`.

## Operation
- Storage: `Depth`-entry register array, write pointer `wr_q`, read pointer `rd_q`, count `cnt_q`.
- Pointers run 0..`Depth-1` and wrap to 0 after `Depth-1`. Explicit wrap compare; no power-of-two masking.
- Push = `valid_i && ready_o`. Pop = `valid_o && ready_i`.
- `ready_o = !full && !flush_i`. `valid_o = !empty && !flush_i`.
- `data_o = mem[rd_q]`, read combinationally. `data_o` is undefined-but-stable when empty; it holds the last entry written at `rd_q`.
- On push: `mem[wr_q] <= data_i` and `wr_q` advances.
- On pop: `rd_q` advances.
- Count update: `cnt_q` += push − pop. Push and pop together leave it unchanged.
- Flush has priority. `wr_q`, `rd_q` and `cnt_q` go to 0 next cycle. Push and pop cannot occur in a flush cycle because `ready_o` and `valid_o` are both 0. Memory contents are not cleared.
- No fall-through: a push into an empty FIFO is visible at `valid_o` one cycle later.
- Full: `ready_o = 0`. A pop in the full cycle does not allow a same-cycle push, which keeps `ready_o` free of any path from `ready_i`.
- Empty: `valid_o = 0`. `ready_i` is ignored.
- Assertions, compiled out under `COMMON_CELLS_ASSERTS_OFF`:
  - `cnt_q <= Depth`.
  - `valid_o` stable and `data_o` stable while `valid_o && !ready_i && !flush_i`.
  - `!(flush_i && valid_o)`.

## Timing
- Reset: synchronous, low `rst_ni` sampled on the clock edge. Pointers, count and all memory entries go to 0.
- Outputs after reset:
  - `valid_o` = 0.
  - `ready_o` = 1 (unless `flush_i`).
  - `usage_o` = 0.
  - `full_o` = 0.
  - `empty_o` = 1.
  - `data_o` = 0.
- Reset during operation: all entries are discarded exactly as a flush, and reset dominates flush, push and pop.
- Latency: input to output is 1 cycle minimum.
- Throughput: 1 item/cycle sustained when neither empty nor full.
- Combinational paths:
  - `flush_i` → `ready_o` and `valid_o`.
  - No path from `valid_i`/`data_i` to `valid_o`/`data_o`.
  - No path from `ready_i` to `ready_o`.
- `usage_o`, `full_o` and `empty_o` are registered-count derived. They reflect state before the current cycle's push, pop or flush.

## Structure
- No package typedefs are required. `T` is passed through from the instantiating stage, and `CntW` is a localparam.
- One sub-module, `fifo_ptr_counter`: `Depth`-modulo pointer with `clr_i` and `en_i`, and synchronous active-low reset. It is instantiated twice, for `wr_q` and `rd_q`.
- The count, memory array, flags and assertions live in the top module.

## Test plan
All scenarios use `Depth=4` and `T=logic[7:0]`.
- **Reset:** hold `rst_ni=0` for 2 cycles with `valid_i=1` → `valid_o=0`, `ready_o=1`, `usage_o=0`, `empty_o=1`, `data_o=8'h00`, and nothing is stored.
- **Fill then drain:** push `8'h11`, `8'h22`, `8'h33`, `8'h44` with `ready_i=0` → `full_o=1`, `usage_o=4`, `ready_o=0`, and the fifth item `8'h55` is refused. Then `ready_i=1` → outputs are `11,22,33,44` in order over 4 cycles, and `empty_o=1`.
- **Wrap-around streaming:** 10 items `8'h01..8'h0A` pushed every cycle with `ready_i=1` → each item appears one cycle after its push, in order, with no loss. `usage_o` stays at 1 and both pointers wrap twice.
- **Flush with content:**
  - Store `8'hA0`, `8'hA1`, `8'hA2`, then pulse `flush_i` with `valid_i=0`.
  - In the flush cycle, `valid_o=0` and `ready_o=0`.
  - On the next cycle, `usage_o=0`.
  - A subsequent push of `8'hB0` emerges as the first output, and no `A*` item appears.
- **Simultaneous push and pop at partial fill:** with `usage_o=2`, `valid_i=1` and `ready_i=1` for 3 cycles → `usage_o` stays 2 and order is preserved.
- **Backpressure stability:** with the head `8'h5A` and `ready_i=0` for 5 cycles → `valid_o=1` and `data_o=8'h5A` are unchanged throughout.

Source files
------------

// File: rtl/stream_fifo_flushable_pkg.sv
// Shared helpers for the flushable stream FIFO slice.
// No ports; provides the pointer-width helper used by the FIFO and its pointer counters.
package stream_fifo_flushable_pkg;

  // A Depth-1 FIFO still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Depth-modulo pointer for the flushable FIFO. The pointer advances on en_i and
// wraps to 0 after Depth-1. Wrapping uses an explicit compare, so Depth need not
// be a power of two. clr_i takes priority over en_i.
// Ports: clk_i clock, rst_ni sync active-low reset, clr_i clear to 0,
//        en_i advance, ptr_o current pointer.
module fifo_ptr_counter
  import stream_fifo_flushable_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = ptr_width(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_fifo_flushable.sv
// Flushable ready/valid FIFO that sits ahead of the NPC spill register.
// Flushing discards all stored entries in the same cycle as the spill register.
// valid_o is never high while flush_i is high. The FIFO has no fall-through path.
// Ports: clk_i clock, rst_ni sync active-low reset, flush_i discard all entries,
//        valid_i/ready_o/data_i upstream handshake, valid_o/ready_i/data_o
//        downstream handshake, usage_o/full_o/empty_o registered fill status.
module stream_fifo_flushable
  import stream_fifo_flushable_pkg::*;
#(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  T                data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output T                data_o,
  output logic [CntW-1:0] usage_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = ptr_width(Depth);

  T                mem [Depth];
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [CntW-1:0] cnt_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);

  // ready_o is computed from the registered count only, so a pop in a full
  // cycle cannot free a slot in that same cycle. This keeps ready_i out of
  // the ready_o path.
  assign ready_o = !full && !flush_i;
  assign valid_o = !empty && !flush_i;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  assign data_o  = mem[rd_q];
  assign usage_o = cnt_q;
  assign full_o  = full;
  assign empty_o = empty;

  fifo_ptr_counter #(
    .Depth (Depth)
  ) i_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .en_i   (push),
    .ptr_o  (wr_q)
  );

  fifo_ptr_counter #(
    .Depth (Depth)
  ) i_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .en_i   (pop),
    .ptr_o  (rd_q)
  );

  // push and pop are both forced low during a flush, so a flush only needs
  // to clear the count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (push && !pop) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_q] <= data_i;
    end
  end

`ifndef COMMON_CELLS_ASSERTS_OFF
  cnt_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(Depth));

  // A stalled head may only be withdrawn by a flush or a reset.
  head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=>
      (flush_i || !rst_ni || (valid_o && $stable(data_o))));

  no_valid_in_flush: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(flush_i && valid_o));
`endif

endmodule

// File: tb/tb_stream_fifo_flushable.sv
module tb_stream_fifo_flushable;

  localparam int unsigned Depth = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic [2:0] usage_o;
  logic       full_o;
  logic       empty_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO contents as a plain queue, head at index 0.
  logic [7:0] model_q[$];

  stream_fifo_flushable #(
    .T     (logic [7:0]),
    .Depth (Depth)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .usage_o (usage_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Compare process: checks the outputs against the queue at mid-cycle, then
  // applies what the coming clock edge will do to the queue.
  initial begin
    bit exp_push, exp_pop;
    int sz;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      sz = model_q.size();
      check("m_valid", valid_o, (sz > 0) && !flush_i);
      check("m_ready", ready_o, (sz < Depth) && !flush_i);
      check("m_usage", usage_o, sz);
      check("m_full",  full_o,  sz == Depth);
      check("m_empty", empty_o, sz == 0);
      if (sz > 0 && !flush_i) check("m_data", data_o, model_q[0]);
      if (!rst_ni || flush_i) begin
        model_q.delete();
      end else begin
        exp_push = valid_i && (sz < Depth);
        exp_pop  = (sz > 0) && ready_i;
        if (exp_pop) void'(model_q.pop_front());
        if (exp_push) model_q.push_back(data_i);
      end
    end
  end

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b1; data_i = 8'hEE; ready_i = 1'b0;

    // Reset with valid_i held high: nothing may be stored.
    step(); step();
    rst_ni = 1'b1; valid_i = 1'b0;
    #2;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_usage", usage_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full",  full_o,  0);
    check("rst_data",  data_o,  8'h00);

    // Fill, then offer a fifth item that must be refused, then drain.
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = fill[i]; step();
    end
    data_i = 8'h55;
    #2;
    check("fill_full",  full_o,  1);
    check("fill_usage", usage_o, 4);
    check("fill_ready", ready_o, 0);
    step();
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("drain_valid", valid_o, 1);
      check("drain_data",  data_o,  fill[i]);
      step();
    end
    #2;
    check("drain_empty", empty_o, 1);

    // Wrap-around streaming: each item appears one cycle after its push.
    for (int i = 1; i <= 10; i++) begin
      valid_i = 1'b1; data_i = 8'(i);
      #2;
      if (i > 1) begin
        check("stream_data",  data_o,  i - 1);
        check("stream_usage", usage_o, 1);
      end
      step();
    end
    valid_i = 1'b0;
    #2;
    check("stream_last", data_o, 8'h0A);
    step();
    ready_i = 1'b0;

    // Flush with content.
    valid_i = 1'b1;
    data_i = 8'hA0; step();
    data_i = 8'hA1; step();
    data_i = 8'hA2; step();
    valid_i = 1'b0; flush_i = 1'b1;
    #2;
    check("flush_valid", valid_o, 0);
    check("flush_ready", ready_o, 0);
    step();
    flush_i = 1'b0;
    #2;
    check("flush_usage", usage_o, 0);
    valid_i = 1'b1; data_i = 8'hB0; step();
    valid_i = 1'b0;
    #2;
    check("flush_first_valid", valid_o, 1);
    check("flush_first_data",  data_o,  8'hB0);
    ready_i = 1'b1; step();
    ready_i = 1'b0;

    // Simultaneous push and pop at usage 2.
    valid_i = 1'b1;
    data_i = 8'hC0; step();
    data_i = 8'hC1; step();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = 8'hC2 + 8'(i);
      #2;
      check("pp_usage", usage_o, 2);
      check("pp_data",  data_o,  8'hC0 + 8'(i));
      step();
    end
    valid_i = 1'b0;
    step(); step();
    ready_i = 1'b0;

    // Backpressure: the head must hold for 5 stalled cycles.
    valid_i = 1'b1;
    data_i = 8'h5A; step();
    data_i = 8'h77; step();
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("bp_valid", valid_o, 1);
      check("bp_data",  data_o,  8'h5A);
      step();
    end
    ready_i = 1'b1; step(); step();

    // Randomised traffic with occasional flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      valid_i = ($urandom_range(3) != 0);
      ready_i = ($urandom_range(2) != 0);
      flush_i = ($urandom_range(15) == 0);
      rst_ni  = ($urandom_range(63) != 0);
      data_i  = 8'($urandom);
      step();
    end
    rst_ni = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
